sync_frame_tx: RTL

- Serial frame transmitter: accepts a parallel payload word over a valid/ready handshake and emits one bit per clock on `k`.
- Frame format: 4-bit sync word 1101, then the payload MSB-first with bit stuffing, then idle zeros.
- Stuffing guarantees the downstream overlapping 1101 Moore detector fires exactly once per frame, on the sync word.
- Sits upstream of the detector on the same single-bit link.

---
 rtl/sync_frame_tx_pkg.sv | 28 ++
 rtl/sync_frame_tx_stuff_hist.sv | 36 +++
 rtl/sync_frame_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sync_frame_tx_pkg.sv
// sync_frame_tx_pkg
// Shared definitions for the serial frame transmitter:
//   - state_e       : FSM state encodings (also visible on the debug port)
//   - SYNC_WORD     : 4-bit frame sync pattern, sent MSB first
//   - STUFF_TRIGGER : link history that forces a stuffed zero before a payload bit
//   - GAP_MIN       : smallest legal number of forced zeros after a payload
package sync_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_STUFF = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam int              SYNC_W        = 4;
  localparam logic [SYNC_W-1:0] SYNC_WORD   = 4'b1101;
  localparam logic [2:0]      STUFF_TRIGGER = 3'b110;
  localparam int              GAP_MIN       = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_frame_tx_stuff_hist.sv
// tx_stuff_hist
// Tracks the last three bits placed on the serial link and flags when the
// next payload bit must be replaced by a stuffed zero.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (clears history to 000)
//   bit_in    in   bit being registered onto the link this edge
//   stuff_req out  history equals STUFF_TRIGGER
module tx_stuff_hist
  import sync_frame_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  output logic stuff_req
);

  logic [2:0] hist_q;
  logic [2:0] hist_d;

  // hist_q[0] always mirrors the bit currently on the link.
  always_comb begin
    hist_d = {hist_q[1:0], bit_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= 3'b000;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign stuff_req = (hist_q == STUFF_TRIGGER);

endmodule

// File: rtl/sync_frame_tx.sv
// sync_frame_tx
// Serial frame transmitter. Accepts a payload word over valid/ready and sends
// sync word 1101, then the payload MSB first with zero-stuffing so that 1101
// never appears inside a frame, then GAP forced zeros before returning to IDLE.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_data    in   payload word (DATA_W bits)
//   in_valid   in   payload offered
//   in_ready   out  high only in IDLE and out of reset
//   k          out  registered serial bit
//   tx_active  out  high in SYNC, DATA, STUFF, GAP
//   frame_done out  high while the last payload bit is on k
//   state      out  current FSM state (debug)
module sync_frame_tx
  import sync_frame_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              k,
  output logic              tx_active,
  output logic              frame_done,
  output logic [2:0]        state
);

  // One counter serves as sync index, payload bit count and gap count.
  localparam int CNT_MAX = max3(DATA_W, SYNC_W, GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e              state_q, state_d;
  logic                k_q, k_d;
  logic                tx_active_q, tx_active_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                xfer;
  logic                stuff_req;
  logic                take_payload;
  logic [CNT_W-1:0]    pay_cnt;
  logic [SYNC_W-1:0]   sync_sh;

  assign in_ready = rst & (state_q == ST_IDLE);
  assign xfer     = in_valid & in_ready;

  // Sync bit to send next is the MSB of the sync word shifted by the
  // number of sync bits already sent.
  assign sync_sh = SYNC_WORD << cnt_q;

  tx_stuff_hist u_hist (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (k_d),
    .stuff_req (stuff_req)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = 1'b0;
    frame_done_d = 1'b0;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    take_payload = 1'b0;
    pay_cnt      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_SYNC;
          k_d     = SYNC_WORD[SYNC_W-1];
          shreg_d = in_data;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_SYNC: begin
        if (cnt_q < CNT_W'(SYNC_W)) begin
          k_d   = sync_sh[SYNC_W-1];
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Sync complete: counter restarts as the payload bit count.
          take_payload = 1'b1;
          pay_cnt      = '0;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          // Final payload bit just went out; never stuff after it.
          state_d = ST_GAP;
          cnt_d   = CNT_W'(1);
        end else begin
          take_payload = 1'b1;
        end
      end

      ST_STUFF: begin
        // History now ends in 0, so the held bit is always released here.
        take_payload = 1'b1;
      end

      ST_GAP: begin
        if (cnt_q < CNT_W'(GAP)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (take_payload) begin
      if (stuff_req) begin
        // Insert a zero and keep the payload bit for the next cycle.
        state_d = ST_STUFF;
        k_d     = 1'b0;
        cnt_d   = pay_cnt;
      end else begin
        state_d      = ST_DATA;
        k_d          = shreg_q[DATA_W-1];
        shreg_d      = {shreg_q[DATA_W-2:0], 1'b0};
        cnt_d        = pay_cnt + CNT_W'(1);
        frame_done_d = (pay_cnt == CNT_W'(DATA_W - 1));
      end
    end

    tx_active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      k_q          <= 1'b0;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
    end
  end

  assign k          = k_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;
  assign state      = state_q;

endmodule
